inta_sequencer: RTL and testbench

CPU-side initiator for the 8259A interrupt-acknowledge protocol. It watches the PIC's INT output and drives the two-pulse INTA# sequence. It captures the vector byte the PIC places on the data bus during the second pulse and hands that vector to the core. When the core finishes servicing, it issues the EOI as an OCW2 write unless automatic EOI is in effect. It sits between the PIC's data-bus/control pins and the core's interrupt-entry logic.

---
 rtl/inta_sequencer_if.sv | 27 ++
 rtl/inta_sequencer.sv | 149 ++++++++++++++
 tb/tb_inta_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inta_sequencer_if.sv
// Pin bundle between inta_sequencer and the PIC / core side.
// master is the sequencer's view; slave is the PIC + core view.
interface inta_sequencer_if;
    logic       intReq;
    logic       enable;
    logic       autoEoi;
    logic       serviceDone;
    logic [7:0] dataBusIn;
    logic       intaN;
    logic       wrN;
    logic       a0;
    logic [7:0] dataBusOut;
    logic       dataBusOe;
    logic [7:0] vectorOut;
    logic       vectorValid;
    logic       busy;

    modport master (
        input  intReq, enable, autoEoi, serviceDone, dataBusIn,
        output intaN, wrN, a0, dataBusOut, dataBusOe, vectorOut, vectorValid, busy
    );

    modport slave (
        output intReq, enable, autoEoi, serviceDone, dataBusIn,
        input  intaN, wrN, a0, dataBusOut, dataBusOe, vectorOut, vectorValid, busy
    );
endinterface

// File: rtl/inta_sequencer.sv
// 8259A interrupt-acknowledge initiator: two INTA# pulses, vector capture, OCW2 EOI write.
// Define SPECIFIC_EOI_EN to send a specific EOI for the captured level instead of 8'h20.
module inta_sequencer #(
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    inta_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, INTA1, GAP1, INTA2, DELIVER, EOIWR, EOIHOLD, RECOVER
    } state_e;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sync1_q, sync1_d, sync2_q, sync2_d;
    logic       inta_n_q, inta_n_d;
    logic       wr_n_q, wr_n_d;
    logic       a0_q, a0_d;
    logic       oe_q, oe_d;
    logic [7:0] dout_q, dout_d;
    logic [7:0] vec_q, vec_d;
    logic       vld_q, vld_d;
    logic       busy_q, busy_d;
    logic [7:0] eoi_byte;
    logic       cnt_zero;

    always_comb begin
`ifdef SPECIFIC_EOI_EN
        eoi_byte = {3'b011, 2'b00, vec_q[2:0]};
`else
        eoi_byte = 8'h20;
`endif
    end

    assign cnt_zero = (cnt_q == 4'd0);

    always_comb begin
        sync1_d = bus.intReq;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 4'd1;
        vec_d   = vec_q;
        vld_d   = vld_q;

        case (state_q)
            IDLE: begin
                if (sync2_q && bus.enable) begin
                    state_d = INTA1;
                    cnt_d   = PULSE_LD;
                end
            end
            INTA1: begin
                if (cnt_zero) begin
                    state_d = GAP1;
                    cnt_d   = GAP_LD;
                end
            end
            GAP1: begin
                if (cnt_zero) begin
                    state_d = INTA2;
                    cnt_d   = PULSE_LD;
                end
            end
            INTA2: begin
                // PIC drives the vector during the second pulse; latch it on the rising INTA# edge
                if (cnt_zero) begin
                    state_d = DELIVER;
                    vec_d   = bus.dataBusIn;
                    vld_d   = 1'b1;
                end
            end
            DELIVER: begin
                if (bus.serviceDone) begin
                    vld_d = 1'b0;
                    if (bus.autoEoi) begin
                        state_d = RECOVER;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = EOIWR;
                        cnt_d   = PULSE_LD;
                    end
                end
            end
            EOIWR: begin
                if (cnt_zero) state_d = EOIHOLD;
            end
            EOIHOLD: begin
                // WR# already high here; data stays driven one cycle for hold time
                state_d = RECOVER;
                cnt_d   = GAP_LD;
            end
            RECOVER: begin
                if (cnt_zero) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        inta_n_d = !(state_d == INTA1 || state_d == INTA2);
        wr_n_d   = (state_d != EOIWR);
        oe_d     = (state_d == EOIWR || state_d == EOIHOLD);
        dout_d   = oe_d ? eoi_byte : 8'h00;
        a0_d     = 1'b0;
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            inta_n_q <= 1'b1;
            wr_n_q   <= 1'b1;
            a0_q     <= 1'b0;
            oe_q     <= 1'b0;
            dout_q   <= 8'h00;
            vec_q    <= 8'h00;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            inta_n_q <= inta_n_d;
            wr_n_q   <= wr_n_d;
            a0_q     <= a0_d;
            oe_q     <= oe_d;
            dout_q   <= dout_d;
            vec_q    <= vec_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.intaN       = inta_n_q;
    assign bus.wrN         = wr_n_q;
    assign bus.a0          = a0_q;
    assign bus.dataBusOut  = dout_q;
    assign bus.dataBusOe   = oe_q;
    assign bus.vectorOut   = vec_q;
    assign bus.vectorValid = vld_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: table-driven acknowledge/EOI runs plus hand-written corner sequences,
// with captured vectors checked against a scoreboard queue.
module tb_inta_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inta_sequencer_if bif ();
    inta_sequencer_if fif ();

    inta_sequencer #(.PULSE_CYCLES(2), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif)
    );
    inta_sequencer #(.PULSE_CYCLES(1), .GAP_CYCLES(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .bus(fif)
    );

    typedef struct {
        logic [7:0] data;
        logic       auto_eoi;
        logic       disturb;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic pop_check(input string name, input logic [7:0] act);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got 0x%0h, expected nothing (scoreboard empty)", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(act), 32'(e));
        end
    endtask

    function automatic logic [31:0] rst_view();
        return {10'h0, bif.intaN, bif.wrN, bif.a0, bif.dataBusOe, bif.busy, bif.vectorValid,
                bif.vectorOut, bif.dataBusOut};
    endfunction

    // One full acknowledge + service run on the default DUT. When armed, intReq is already
    // high and the next rising edge is E0.
    task automatic run_seq(input logic [7:0] data, input logic auto_eoi,
                           input logic disturb, input logic armed);
        logic [8:0] tr_inta;
        logic [1:0] tr_vld;
        logic [5:0] tr_wr, tr_oe, tr_busy;
        logic [7:0] exp_eoi, eoi_seen;
        logic       a0_seen, vld_after;
        tr_inta = '0; tr_vld = '0; tr_wr = '0; tr_oe = '0; tr_busy = '0;
        eoi_seen = '0; a0_seen = 1'b1; vld_after = 1'b1;
`ifdef SPECIFIC_EOI_EN
        exp_eoi = {3'b011, 2'b00, data[2:0]};
`else
        exp_eoi = 8'h20;
`endif
        if (!armed) begin
            @(negedge clk);
            bif.intReq = 1'b1;
        end
        bif.dataBusIn = 8'hEE;
        for (int e = 0; e <= 8; e++) begin
            tick();
            tr_inta = {tr_inta[7:0], bif.intaN};
            if (e >= 7) tr_vld = {tr_vld[0], bif.vectorValid};
            if (disturb && e == 2) begin
                bif.intReq = 1'b0;
                bif.enable = 1'b0;
            end
            if (disturb && e == 4) bif.serviceDone = 1'b1;
            if (e == 5) bif.serviceDone = 1'b0;
            if (e == 7) begin
                bif.dataBusIn = data;
                exp_q.push_back(data);
            end
        end
        check("inta_trace", 32'(tr_inta), 32'(9'b110011001));
        check("vld_rise", 32'(tr_vld), 32'(2'b01));
        pop_check("vector", bif.vectorOut);
        bif.dataBusIn = 8'hEE;
        bif.intReq    = 1'b0;
        bif.enable    = 1'b1;
        repeat (2) tick();
        check("deliver_hold", 32'({bif.vectorValid, bif.busy, bif.intaN, bif.wrN}), 32'(4'b1111));
        @(negedge clk);
        bif.serviceDone = 1'b1;
        bif.autoEoi     = auto_eoi;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                eoi_seen        = bif.dataBusOut;
                a0_seen         = bif.a0;
                vld_after       = bif.vectorValid;
                bif.serviceDone = 1'b0;
                bif.autoEoi     = ~auto_eoi;
            end
            tr_wr   = {tr_wr[4:0], bif.wrN};
            tr_oe   = {tr_oe[4:0], bif.dataBusOe};
            tr_busy = {tr_busy[4:0], bif.busy};
        end
        bif.autoEoi = 1'b0;
        check("vld_clear", 32'(vld_after), 32'(1'b0));
        if (auto_eoi) begin
            check("aeoi_wr_trace", 32'(tr_wr), 32'(6'b111111));
            check("aeoi_oe_trace", 32'(tr_oe), 32'(6'b000000));
            check("aeoi_busy_trace", 32'(tr_busy), 32'(6'b110000));
        end else begin
            check("eoi_wr_trace", 32'(tr_wr), 32'(6'b001111));
            check("eoi_oe_trace", 32'(tr_oe), 32'(6'b111000));
            check("eoi_busy_trace", 32'(tr_busy), 32'(6'b111110));
            check("eoi_byte_a0", 32'({a0_seen, eoi_seen}), 32'({1'b0, exp_eoi}));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[4];
        logic [1:0] seen;
        logic [5:0] tr6;
        logic [3:0] fw, fo, fb;
        logic [7:0] feoi, fexp;

        tbl[0] = '{data: 8'h4B, auto_eoi: 1'b0, disturb: 1'b0};
        tbl[1] = '{data: 8'hA5, auto_eoi: 1'b1, disturb: 1'b0};
        tbl[2] = '{data: 8'h07, auto_eoi: 1'b0, disturb: 1'b1};
        tbl[3] = '{data: 8'hF8, auto_eoi: 1'b1, disturb: 1'b1};

        rst_n = 1'b0;
        bif.intReq = 1'b0; bif.enable = 1'b1; bif.autoEoi = 1'b0;
        bif.serviceDone = 1'b0; bif.dataBusIn = 8'h00;
        fif.intReq = 1'b0; fif.enable = 1'b1; fif.autoEoi = 1'b0;
        fif.serviceDone = 1'b0; fif.dataBusIn = 8'h00;

        repeat (2) tick();
        check("reset_state", rst_view(), {10'h0, 6'b110000, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 4; i++)
            run_seq(tbl[i].data, tbl[i].auto_eoi, tbl[i].disturb, 1'b0);

        // Sub-cycle glitch that never straddles a rising edge
        @(negedge clk);
        #1 bif.intReq = 1'b1;
        #3 bif.intReq = 1'b0;
        seen = '0;
        repeat (8) begin
            tick();
            seen |= {~bif.intaN, bif.busy};
        end
        check("glitch_no_inta", 32'(seen), 32'd0);

        // intReq held while interrupts are disabled
        bif.enable = 1'b0;
        @(negedge clk);
        bif.intReq = 1'b1;
        seen = '0;
        repeat (6) begin
            tick();
            seen |= {~bif.intaN, bif.busy};
        end
        bif.intReq = 1'b0;
        repeat (3) begin
            tick();
            seen |= {~bif.intaN, bif.busy};
        end
        bif.enable = 1'b1;
        repeat (3) begin
            tick();
            seen |= {~bif.intaN, bif.busy};
        end
        check("disabled_no_inta", 32'(seen), 32'd0);

        // Asynchronous reset while in GAP1, then a held intReq restarts the sequence
        @(negedge clk);
        bif.intReq = 1'b1;
        repeat (5) tick();
        check("gap1_reached", 32'({bif.intaN, bif.busy}), 32'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_gap1", rst_view(), {10'h0, 6'b110000, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(8'h3C, 1'b1, 1'b0, 1'b1);

        // Minimum pulse/gap widths on the second instance
`ifdef SPECIFIC_EOI_EN
        fexp = 8'h61;
`else
        fexp = 8'h20;
`endif
        tr6 = '0;
        @(negedge clk);
        fif.intReq = 1'b1;
        fif.dataBusIn = 8'hEE;
        for (int e = 0; e <= 5; e++) begin
            tick();
            tr6 = {tr6[4:0], fif.intaN};
            if (e == 4) begin
                fif.dataBusIn = 8'h91;
                exp_q.push_back(8'h91);
            end
        end
        check("fast_inta_trace", 32'(tr6), 32'(6'b110101));
        check("fast_vld", 32'(fif.vectorValid), 32'(1'b1));
        pop_check("fast_vector", fif.vectorOut);
        fif.dataBusIn = 8'hEE;
        fif.intReq = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        fif.serviceDone = 1'b1;
        fw = '0; fo = '0; fb = '0; feoi = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                feoi = fif.dataBusOut;
                fif.serviceDone = 1'b0;
            end
            fw = {fw[2:0], fif.wrN};
            fo = {fo[2:0], fif.dataBusOe};
            fb = {fb[2:0], fif.busy};
        end
        check("fast_wr_trace", 32'(fw), 32'(4'b0111));
        check("fast_oe_trace", 32'(fo), 32'(4'b1100));
        check("fast_busy_trace", 32'(fb), 32'(4'b1110));
        check("fast_eoi_byte", 32'(feoi), 32'(fexp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
